// File: rtl/tlc_chain_rx.sv
// tlc_chain_rx: receive-side model of one daisy-chained TLC5940-style driver
// chain. It shifts serial grayscale data in on led_sclk, latches the data on
// led_xlat and produces per-channel PWM from led_gsclk and led_blank.
// Optional feature macro: TLC_RX_BITCHECK_EN. When defined, an xlat that does
// not follow exactly one frame of sclk rises sets the sticky frame_err flag.
module tlc_chain_rx #(
  parameter int CHIPS    = 3,
  parameter int CHANNELS = 16,
  parameter int GS_BITS  = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      led_sclk,
  input  logic                      led_sin,
  input  logic                      led_mode,
  input  logic                      led_blank,
  input  logic                      led_xlat,
  input  logic                      led_gsclk,
  output logic                      led_sout,
  output logic [CHIPS*CHANNELS-1:0] pwm_out,
  output logic                      frame_strobe,
  output logic                      frame_err
);

  localparam int NCH = CHIPS * CHANNELS;
  localparam int N   = NCH * GS_BITS;
  localparam logic [GS_BITS-1:0] GS_MAX = '1;

  // Bit positions of the asynchronous inputs inside the synchronizer vector.
  localparam int I_SCLK  = 0;
  localparam int I_SIN   = 1;
  localparam int I_MODE  = 2;
  localparam int I_BLANK = 3;
  localparam int I_XLAT  = 4;
  localparam int I_GSCLK = 5;

  logic [5:0] raw_in;
  logic [5:0] sync1_q;
  logic [5:0] sync2_q;
  // Third stage only for the inputs that need edge detection: {gsclk, xlat, sclk}.
  logic [2:0] sync3_q;

  logic sclk_rise, xlat_rise, gsclk_rise;
  logic sin_s, mode_s, blank_s;

  logic [N-1:0]       shreg_q, shreg_d;
  logic [N-1:0]       gs_q, gs_d;
  logic [GS_BITS-1:0] gs_cnt_q, gs_cnt_d;
  logic               done_q, done_d;
  logic [NCH-1:0]     pwm_q, pwm_d;
  logic               strobe_q, strobe_d;

  assign raw_in = {led_gsclk, led_xlat, led_blank, led_mode, led_sin, led_sclk};

  // Two-flop synchronizer on every input plus a third flop for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      sync3_q <= {sync2_q[I_GSCLK], sync2_q[I_XLAT], sync2_q[I_SCLK]};
    end
  end

  assign sclk_rise  = sync2_q[I_SCLK]  & ~sync3_q[0];
  assign xlat_rise  = sync2_q[I_XLAT]  & ~sync3_q[1];
  assign gsclk_rise = sync2_q[I_GSCLK] & ~sync3_q[2];
  assign sin_s      = sync2_q[I_SIN];
  assign mode_s     = sync2_q[I_MODE];
  assign blank_s    = sync2_q[I_BLANK];

  // Shift path and grayscale latch; the latch takes the pre-shift contents
  // when xlat and sclk rise together, while the shift still proceeds.
  always_comb begin
    shreg_d  = shreg_q;
    gs_d     = gs_q;
    strobe_d = 1'b0;
    if (sclk_rise) begin
      shreg_d = {shreg_q[N-2:0], sin_s};
    end
    if (xlat_rise && !mode_s) begin
      gs_d     = shreg_q;
      strobe_d = 1'b1;
    end
  end

  // Grayscale counter: cleared by blank, stops at full scale and raises done.
  always_comb begin
    gs_cnt_d = gs_cnt_q;
    done_d   = done_q;
    if (blank_s) begin
      gs_cnt_d = '0;
      done_d   = 1'b0;
    end else if (gsclk_rise && !done_q) begin
      if (gs_cnt_q == GS_MAX) begin
        done_d = 1'b1;
      end else begin
        gs_cnt_d = gs_cnt_q + 1'b1;
      end
    end
  end

  // Per-channel comparator against the next-state counter and latch contents.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_pwm
    assign pwm_d[gi] = !blank_s && !done_d &&
                       (gs_cnt_d < gs_d[gi*GS_BITS +: GS_BITS]);
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg_q  <= '0;
      gs_q     <= '0;
      gs_cnt_q <= '0;
      done_q   <= 1'b0;
      pwm_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      gs_q     <= gs_d;
      gs_cnt_q <= gs_cnt_d;
      done_q   <= done_d;
      pwm_q    <= pwm_d;
      strobe_q <= strobe_d;
    end
  end

  assign led_sout     = shreg_q[N-1];
  assign pwm_out      = pwm_q;
  assign frame_strobe = strobe_q;

`ifdef TLC_RX_BITCHECK_EN
  localparam logic [12:0] CNT_MAX = '1;
  localparam logic [12:0] CNT_N   = 13'(N);

  logic [12:0] sclk_cnt_q, sclk_cnt_d;
  logic        err_q, err_d;

  // Count sclk rises since the last xlat; a same-clock sclk counts toward the next frame.
  always_comb begin
    sclk_cnt_d = sclk_cnt_q;
    err_d      = err_q;
    if (xlat_rise) begin
      sclk_cnt_d = sclk_rise ? 13'd1 : 13'd0;
      if (sclk_cnt_q != CNT_N) begin
        err_d = 1'b1;
      end
    end else if (sclk_rise && (sclk_cnt_q != CNT_MAX)) begin
      sclk_cnt_d = sclk_cnt_q + 13'd1;
    end
  end

  // Bit counter and sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      sclk_cnt_q <= sclk_cnt_d;
      err_q      <= err_d;
    end
  end

  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_tlc_chain_rx.sv
// Bench for tlc_chain_rx. Stimulus tasks update a small behavioural model and
// queue every expected output change; monitors pop and compare whenever the
// DUT output actually changes (or frame_strobe pulses).
`timescale 1ns/1ps
module tb_tlc_chain_rx;

  localparam int N   = 576;
  localparam int NCH = 48;
`ifdef TLC_RX_BITCHECK_EN
  localparam bit BITCHECK = 1'b1;
`else
  localparam bit BITCHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sclk = 1'b0, sin = 1'b0, mode = 1'b0, blank = 1'b1, xlat = 1'b0, gsclk = 1'b0;
  logic            sout;
  logic [NCH-1:0]  pwm;
  logic            strobe;
  logic            err;

  int checks   = 0;
  int failures = 0;
  int ev       = 0;
  bit mon_on   = 1'b0;

  typedef struct {
    logic [47:0] val;
    int          stamp;
  } exp_t;

  exp_t q_pwm[$];
  exp_t q_sout[$];
  exp_t q_err[$];
  int   q_strobe[$];

  // Behavioural model state
  logic [N-1:0]   m_sh = '0;
  logic [N-1:0]   m_gs = '0;
  logic [11:0]    m_cnt = '0;
  bit             m_done = 1'b0;
  bit             m_blank = 1'b1;
  bit             m_err = 1'b0;
  int             m_sclk = 0;
  logic [NCH-1:0] e_pwm = '0;
  logic           e_sout = 1'b0;
  logic           e_err = 1'b0;

  tlc_chain_rx dut (
    .clock        (clk),
    .reset        (rst),
    .led_sclk     (sclk),
    .led_sin      (sin),
    .led_mode     (mode),
    .led_blank    (blank),
    .led_xlat     (xlat),
    .led_gsclk    (gsclk),
    .led_sout     (sout),
    .pwm_out      (pwm),
    .frame_strobe (strobe),
    .frame_err    (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [NCH-1:0] model_pwm();
    logic [NCH-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++)
      r[k] = !m_blank && !m_done && (m_cnt < m_gs[k*12 +: 12]);
    return r;
  endfunction

  task automatic push_exp();
    exp_t t;
    logic [NCH-1:0] p;
    p = model_pwm();
    if (p != e_pwm) begin
      t.val = p; t.stamp = ev; q_pwm.push_back(t); e_pwm = p;
    end
    if (m_sh[N-1] != e_sout) begin
      t.val = {47'd0, m_sh[N-1]}; t.stamp = ev; q_sout.push_back(t); e_sout = m_sh[N-1];
    end
    if (m_err != e_err) begin
      t.val = {47'd0, m_err}; t.stamp = ev; q_err.push_back(t); e_err = m_err;
    end
  endtask

  task automatic shift_bit(input logic b);
    ev++;
    sin = b; sclk = 1'b1;
    m_sh = {m_sh[N-2:0], b};
    if (m_sclk < 8191) m_sclk++;
    push_exp();
    cyc(2);
    sclk = 1'b0;
    cyc(2);
  endtask

  task automatic shift_frame(input logic [N-1:0] f, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) shift_bit(f[i]);
  endtask

  task automatic do_xlat(input logic md);
    ev++;
    mode = md; xlat = 1'b1;
    if (BITCHECK && m_sclk != N) m_err = 1'b1;
    if (!md) begin
      m_gs = m_sh;
      q_strobe.push_back(ev);
    end
    m_sclk = 0;
    push_exp();
    cyc(2);
    xlat = 1'b0;
    cyc(2);
    mode = 1'b0;
  endtask

  task automatic xlat_and_shift(input logic b);
    ev++;
    mode = 1'b0; sin = b; sclk = 1'b1; xlat = 1'b1;
    if (BITCHECK && m_sclk != N) m_err = 1'b1;
    m_gs = m_sh;
    q_strobe.push_back(ev);
    m_sh = {m_sh[N-2:0], b};
    m_sclk = 1;
    push_exp();
    cyc(2);
    sclk = 1'b0; xlat = 1'b0;
    cyc(2);
  endtask

  task automatic set_blank(input logic v);
    ev++;
    blank = v; m_blank = v;
    if (v) begin
      m_cnt = '0; m_done = 1'b0;
    end
    push_exp();
    cyc(4);
  endtask

  task automatic gs_run(input int n);
    for (int i = 0; i < n; i++) begin
      ev++;
      gsclk = 1'b1;
      if (!m_blank && !m_done) begin
        if (m_cnt == 12'hFFF) m_done = 1'b1;
        else m_cnt = m_cnt + 12'd1;
      end
      push_exp();
      cyc(2);
      gsclk = 1'b0;
      cyc(2);
    end
  endtask

  task automatic check_drained(input string tag);
    chk({tag, " pwm_left"},    48'(q_pwm.size()),    48'd0);
    chk({tag, " sout_left"},   48'(q_sout.size()),   48'd0);
    chk({tag, " err_left"},    48'(q_err.size()),    48'd0);
    chk({tag, " strobe_left"}, 48'(q_strobe.size()), 48'd0);
    q_pwm.delete(); q_sout.delete(); q_err.delete(); q_strobe.delete();
  endtask

  task automatic do_reset(input string tag);
    if (mon_on) check_drained(tag);
    rst = 1'b1;
    #1;
    chk({tag, " rst_pwm"},    {{(48-NCH){1'b0}}, pwm}, 48'd0);
    chk({tag, " rst_sout"},   {47'd0, sout},   48'd0);
    chk({tag, " rst_strobe"}, {47'd0, strobe}, 48'd0);
    chk({tag, " rst_err"},    {47'd0, err},    48'd0);
    cyc(2);
    rst = 1'b0;
    m_sh = '0; m_gs = '0; m_cnt = '0; m_done = 1'b0; m_err = 1'b0; m_sclk = 0;
    e_pwm = '0; e_sout = 1'b0; e_err = 1'b0;
    mon_on = 1'b1;
    ev++;
    cyc(4);
  endtask

  function automatic logic [N-1:0] frame_mixed();
    logic [N-1:0] f;
    f = '0;
    for (int k = 0; k < NCH; k++)
      f[k*12 +: 12] = (k % 2 == 0) ? 12'(k + 1) : 12'(12'hA00 + k);
    return f;
  endfunction

  function automatic logic [N-1:0] frame_fill(input logic [11:0] v);
    logic [N-1:0] f;
    for (int k = 0; k < NCH; k++) f[k*12 +: 12] = v;
    return f;
  endfunction

  // Monitors: sample on the falling edge, away from the active edge.
  logic [NCH-1:0] seen_pwm = '0;
  logic           seen_sout = 1'b0;
  logic           seen_err = 1'b0;

  always @(negedge clk) begin
    if (rst || !mon_on) begin
      seen_pwm = pwm;
    end else if (pwm !== seen_pwm) begin
      checks++;
      if (q_pwm.size() == 0) begin
        failures++;
        $display("FAIL pwm_unexpected: got %h at ev %0d, required no change", pwm, ev);
      end else begin
        exp_t t;
        t = q_pwm.pop_front();
        if (pwm !== t.val[NCH-1:0] || ev != t.stamp) begin
          failures++;
          $display("FAIL pwm_change: got %h at ev %0d, required %h at ev %0d",
                   pwm, ev, t.val[NCH-1:0], t.stamp);
        end else begin
          $display("pwm    ev=%0d value=%h", ev, pwm);
        end
      end
      seen_pwm = pwm;
    end
  end

  always @(negedge clk) begin
    if (rst || !mon_on) begin
      seen_sout = sout;
    end else if (sout !== seen_sout) begin
      checks++;
      if (q_sout.size() == 0) begin
        failures++;
        $display("FAIL sout_unexpected: got %b at ev %0d, required no change", sout, ev);
      end else begin
        exp_t t;
        t = q_sout.pop_front();
        if (sout !== t.val[0] || ev != t.stamp) begin
          failures++;
          $display("FAIL sout_change: got %b at ev %0d, required %b at ev %0d",
                   sout, ev, t.val[0], t.stamp);
        end else begin
          $display("sout   ev=%0d value=%b", ev, sout);
        end
      end
      seen_sout = sout;
    end
  end

  always @(negedge clk) begin
    if (rst || !mon_on) begin
      seen_err = err;
    end else if (err !== seen_err) begin
      checks++;
      if (q_err.size() == 0) begin
        failures++;
        $display("FAIL err_unexpected: got %b at ev %0d, required no change", err, ev);
      end else begin
        exp_t t;
        t = q_err.pop_front();
        if (err !== t.val[0] || ev != t.stamp) begin
          failures++;
          $display("FAIL err_change: got %b at ev %0d, required %b at ev %0d",
                   err, ev, t.val[0], t.stamp);
        end else begin
          $display("err    ev=%0d value=%b", ev, err);
        end
      end
      seen_err = err;
    end
  end

  always @(negedge clk) begin
    if (!rst && mon_on && strobe === 1'b1) begin
      checks++;
      if (q_strobe.size() == 0) begin
        failures++;
        $display("FAIL strobe_unexpected: got pulse at ev %0d, required none", ev);
      end else begin
        int s;
        s = q_strobe.pop_front();
        if (s != ev) begin
          failures++;
          $display("FAIL strobe_stamp: got pulse at ev %0d, required ev %0d", ev, s);
        end else begin
          $display("strobe ev=%0d", ev);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] f;
    cyc(1);
    do_reset("init");

    // Single channel at half scale: ch0 on for exactly 2048 gsclks.
    f = '0;
    f[11:0] = 12'h800;
    shift_frame(f, N);
    do_xlat(1'b0);
    set_blank(1'b0);
    gs_run(4096);
    set_blank(1'b1);
    check_drained("half");

    // Full scale everywhere: on for 4095 gsclks, off until blank clears.
    shift_frame(frame_fill(12'hFFF), N);
    do_xlat(1'b0);
    set_blank(1'b0);
    gs_run(4096);
    set_blank(1'b1);
    set_blank(1'b0);
    set_blank(1'b1);
    check_drained("full");

    // Reset in the middle of a shift while outputs are active.
    set_blank(1'b0);
    shift_frame(frame_fill(12'h5A3), 100);
    do_reset("midshift");
    set_blank(1'b1);
    shift_frame(frame_mixed(), N);
    do_xlat(1'b0);
    set_blank(1'b0);
    gs_run(60);
    set_blank(1'b1);
    check_drained("reload");

    // Dot-correction frame: latch untouched, old frame emerges on sout.
    shift_frame(frame_fill(12'h555), N);
    do_xlat(1'b1);
    set_blank(1'b0);
    gs_run(60);
    set_blank(1'b1);
    check_drained("dotcorr");

    // Short frame followed by a correct one.
    shift_frame(frame_fill(12'h555), N - 1);
    do_xlat(1'b0);
    shift_frame(frame_mixed(), N);
    do_xlat(1'b0);
    check_drained("bitcount");

    // xlat coincident with an sclk rise.
    do_reset("coincide");
    shift_frame(frame_mixed(), N);
    xlat_and_shift(1'b1);
    set_blank(1'b0);
    gs_run(60);
    set_blank(1'b1);
    shift_frame(frame_fill(12'h0F0), N - 1);
    do_xlat(1'b0);
    check_drained("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
